// File: rtl/mprj_io_cfg_loader.sv
// rtl/mprj_io_cfg_loader.sv - serial configuration loader for the user-project GPIO pad chain
// Shifts a captured PADS*CFG_BITS image out MSB first over serial_clock/serial_data, then strobes serial_load.
module mprj_io_cfg_loader #(
  parameter int PADS     = 38,
  parameter int CFG_BITS = 13,
  parameter int CLK_DIV  = 2
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     xfer,
  input  logic [PADS*CFG_BITS-1:0] cfg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     serial_clock,
  output logic                     serial_data,
  output logic                     serial_load
);

  localparam int TOTAL = PADS * CFG_BITS;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LOAD} state_t;

  state_t           state, state_n;
  logic [TOTAL-1:0] shreg, shreg_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n, bit_inc;
  logic [DIV_W-1:0] div_cnt, div_cnt_n;
  logic             done_n;
  logic             div_end;

  assign div_end = (div_cnt == DIV_LAST);
  assign bit_inc = bit_cnt + CNT_W'(1);

  // Outputs are registered from the next-state values so they line up with the state they describe.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      div_cnt      <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      serial_clock <= 1'b0;
      serial_data  <= 1'b0;
      serial_load  <= 1'b0;
    end else begin
      state        <= state_n;
      shreg        <= shreg_n;
      bit_cnt      <= bit_cnt_n;
      div_cnt      <= div_cnt_n;
      busy         <= (state_n != IDLE);
      done         <= done_n;
      serial_clock <= (state_n == HIGH);
      serial_data  <= ((state_n == LOW) || (state_n == HIGH)) && shreg_n[TOTAL-1];
      serial_load  <= (state_n == LOAD);
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    div_cnt_n = div_cnt;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        if (xfer) begin
          shreg_n   = cfg_data;
          bit_cnt_n = '0;
          div_cnt_n = '0;
          state_n   = LOW;
        end
      end
      LOW: begin
        if (div_end) begin
          div_cnt_n = '0;
          state_n   = HIGH;
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end
      HIGH: begin
        if (div_end) begin
          div_cnt_n = '0;
          shreg_n   = {shreg[TOTAL-2:0], 1'b0};
          bit_cnt_n = bit_inc;
          state_n   = (bit_inc == LAST_BIT) ? LOAD : LOW;
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end
      LOAD: begin
        if (div_end) begin
          div_cnt_n = '0;
          done_n    = 1'b1;
          state_n   = IDLE;
        end else begin
          div_cnt_n = div_cnt + DIV_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mprj_io_cfg_loader.sv
// tb/tb_mprj_io_cfg_loader.sv - directed bench for mprj_io_cfg_loader
// Three instances: 2 pads / div 2, 38 pads / div 2, 2 pads / div 1, each feeding a chain model.
module tb_mprj_io_cfg_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          resetn_a, resetn_b, resetn_c;
  logic          xfer_a, xfer_b, xfer_c;
  logic [25:0]   cfg_a, cfg_c;
  logic [493:0]  cfg_b;
  logic busy_a, done_a, sclk_a, sdata_a, load_a;
  logic busy_b, done_b, sclk_b, sdata_b, load_b;
  logic busy_c, done_c, sclk_c, sdata_c, load_c;

  mprj_io_cfg_loader #(.PADS(2), .CFG_BITS(13), .CLK_DIV(2)) u_a (
    .clock(clock), .resetn(resetn_a), .xfer(xfer_a), .cfg_data(cfg_a),
    .busy(busy_a), .done(done_a), .serial_clock(sclk_a), .serial_data(sdata_a), .serial_load(load_a));

  mprj_io_cfg_loader #(.PADS(38), .CFG_BITS(13), .CLK_DIV(2)) u_b (
    .clock(clock), .resetn(resetn_b), .xfer(xfer_b), .cfg_data(cfg_b),
    .busy(busy_b), .done(done_b), .serial_clock(sclk_b), .serial_data(sdata_b), .serial_load(load_b));

  mprj_io_cfg_loader #(.PADS(2), .CFG_BITS(13), .CLK_DIV(1)) u_c (
    .clock(clock), .resetn(resetn_c), .xfer(xfer_c), .cfg_data(cfg_c),
    .busy(busy_c), .done(done_c), .serial_clock(sclk_c), .serial_data(sdata_c), .serial_load(load_c));

  // Chain models: each control block passes bits downstream on serial_clock and latches on serial_load.
  int edges_a = 0, edges_b = 0, edges_c = 0;
  int loads_a = 0, loads_b = 0, loads_c = 0;
  int dones_c = 0;
  logic [25:0]  chain_a = '0, latch_a = '0, chain_c = '0, latch_c = '0;
  logic [493:0] chain_b = '0, latch_b = '0;

  always @(posedge sclk_a) begin edges_a <= edges_a + 1; chain_a <= {chain_a[24:0], sdata_a}; end
  always @(posedge sclk_b) begin edges_b <= edges_b + 1; chain_b <= {chain_b[492:0], sdata_b}; end
  always @(posedge sclk_c) begin edges_c <= edges_c + 1; chain_c <= {chain_c[24:0], sdata_c}; end
  always @(posedge load_a) begin loads_a <= loads_a + 1; latch_a <= chain_a; end
  always @(posedge load_b) begin loads_b <= loads_b + 1; latch_b <= chain_b; end
  always @(posedge load_c) begin loads_c <= loads_c + 1; latch_c <= chain_c; end
  always @(negedge clock) if (done_c) dones_c <= dones_c + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Counts cycles after xfer is sampled (cycle 1 = first cycle after the sampling edge) until done.
  task automatic wait_done(input int sel, input int limit, input bit drop,
                           output int cyc, output int busy_cyc, output int load_cyc,
                           output int first_load, output int first_sclk, output logic d1);
    logic b, d, sc, sd, ld;
    cyc = 0; busy_cyc = 0; load_cyc = 0; first_load = -1; first_sclk = -1; d1 = 1'bx;
    d = 1'b0;
    while (!d && cyc < limit) begin
      @(negedge clock);
      cyc++;
      case (sel)
        0:       {b, d, sc, sd, ld} = {busy_a, done_a, sclk_a, sdata_a, load_a};
        1:       {b, d, sc, sd, ld} = {busy_b, done_b, sclk_b, sdata_b, load_b};
        default: {b, d, sc, sd, ld} = {busy_c, done_c, sclk_c, sdata_c, load_c};
      endcase
      if (cyc == 1) d1 = sd;
      if (b) busy_cyc++;
      if (ld) begin load_cyc++; if (first_load < 0) first_load = cyc; end
      if (sc && first_sclk < 0) first_sclk = cyc;
      if (drop && cyc == 1) begin
        case (sel)
          0:       xfer_a = 1'b0;
          1:       xfer_b = 1'b0;
          default: xfer_c = 1'b0;
        endcase
      end
      if (sel == 2) xfer_c = (cyc == 10 || cyc == 53);
    end
    chk("done_seen", d, 1);
  endtask

  int cyc, bc, lc, fl, fs, e0, l0, d0;
  logic d1, any;
  logic [493:0] old_b, img2;

  initial begin
    resetn_a = 0; resetn_b = 0; resetn_c = 0;
    xfer_a = 0; xfer_b = 0; xfer_c = 0;
    cfg_a = 26'h2AB_CDEF;
    cfg_c = 26'h155_3C3A;
    for (int p = 0; p < 38; p++) cfg_b[p*13 +: 13] = (p % 2 == 0) ? 13'h1803 : 13'h0403;
    for (int p = 0; p < 38; p++) img2[p*13 +: 13] = 13'((p * 311 + 77) % 8192);

    repeat (3) @(negedge clock);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_sclk", sclk_a, 0);
    chk("rst_sdata", sdata_a, 0);
    chk("rst_load", load_a, 0);
    chk("rst_b", {busy_b, done_b, sclk_b, sdata_b, load_b}, 0);
    chk("rst_c", {busy_c, done_c, sclk_c, sdata_c, load_c}, 0);
    resetn_a = 1; resetn_b = 1; resetn_c = 1;
    any = 0;
    repeat (100) begin
      @(negedge clock);
      any |= |{busy_a, done_a, sclk_a, sdata_a, load_a, busy_b, done_b, sclk_b, sdata_b, load_b,
               busy_c, done_c, sclk_c, sdata_c, load_c};
    end
    chk("idle_quiet", any, 0);

    // Bit order, 2 pads, divide by 2
    e0 = edges_a; l0 = loads_a;
    xfer_a = 1;
    wait_done(0, 300, 1, cyc, bc, lc, fl, fs, d1);
    chk("a_done_cycle", cyc, 107);
    chk("a_busy_cycles", bc, 106);
    chk("a_load_cycles", lc, 2);
    chk("a_load_first", fl, 105);
    chk("a_first_sclk", fs, 3);
    chk("a_first_bit", d1, 1);
    chk("a_edges", edges_a - e0, 26);
    chk("a_loads", loads_a - l0, 1);
    chk("a_chain", chain_a, 26'h2AB_CDEF);
    chk("a_latch", latch_a, 26'h2AB_CDEF);

    // Default geometry, 38 pads
    e0 = edges_b; l0 = loads_b;
    xfer_b = 1;
    wait_done(1, 2100, 1, cyc, bc, lc, fl, fs, d1);
    chk("b_done_cycle", cyc, 1979);
    chk("b_busy_cycles", bc, 1978);
    chk("b_edges", edges_b - e0, 494);
    chk("b_loads", loads_b - l0, 1);
    for (int p = 0; p < 38; p++)
      chk($sformatf("b_pad%0d", p), latch_b[p*13 +: 13], (p % 2 == 0) ? 13'h1803 : 13'h0403);

    // Busy masking, divide by 1: extra xfer at edge 10 and on the edge that raises done
    e0 = edges_c; l0 = loads_c; d0 = dones_c;
    xfer_c = 1;
    wait_done(2, 100, 1, cyc, bc, lc, fl, fs, d1);
    chk("c_done_cycle", cyc, 54);
    chk("c_busy_cycles", bc, 53);
    any = 0;
    repeat (30) begin @(negedge clock); any |= busy_c; end
    chk("c_no_retrigger", any, 0);
    chk("c_edges", edges_c - e0, 26);
    chk("c_loads", loads_c - l0, 1);
    chk("c_dones", dones_c - d0, 1);
    chk("c_latch", latch_c, 26'h155_3C3A);

    // Back-to-back with xfer held high
    cfg_a = 26'h1F0_5A3C;
    e0 = edges_a; l0 = loads_a;
    xfer_a = 1;
    wait_done(0, 300, 0, cyc, bc, lc, fl, fs, d1);
    chk("bb_first_done", cyc, 107);
    @(negedge clock);
    chk("bb_restart_busy", busy_a, 1);
    chk("bb_restart_sclk", sclk_a, 0);
    chk("bb_restart_load", load_a, 0);
    xfer_a = 0;
    wait_done(0, 300, 0, cyc, bc, lc, fl, fs, d1);
    chk("bb_second_done", cyc, 106);
    chk("bb_edges", edges_a - e0, 52);
    chk("bb_loads", loads_a - l0, 2);
    chk("bb_latch", latch_a, 26'h1F0_5A3C);

    // Reset in the middle of the shift
    old_b = latch_b;
    cfg_b = img2;
    e0 = edges_b; l0 = loads_b;
    xfer_b = 1;
    @(negedge clock);
    xfer_b = 0;
    for (int i = 0; i < 1000 && (edges_b - e0) < 100; i++) @(negedge clock);
    chk("mid_reach_bit100", edges_b - e0, 100);
    #2 resetn_b = 0;
    #1;
    chk("mid_rst_outputs", {busy_b, done_b, sclk_b, sdata_b, load_b}, 0);
    @(negedge clock);
    chk("mid_rst_hold", {busy_b, done_b, sclk_b, sdata_b, load_b}, 0);
    chk("mid_no_load", loads_b - l0, 0);
    chk("mid_latch_kept", latch_b === old_b, 1);
    resetn_b = 1;
    @(negedge clock);
    e0 = edges_b;
    xfer_b = 1;
    wait_done(1, 2100, 1, cyc, bc, lc, fl, fs, d1);
    chk("mid_redo_done", cyc, 1979);
    chk("mid_redo_edges", edges_b - e0, 494);
    for (int p = 0; p < 38; p++)
      chk($sformatf("mid_pad%0d", p), latch_b[p*13 +: 13], img2[p*13 +: 13]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mprj_io_cfg_loader.md
# mprj_io_cfg_loader

Serial configuration loader for the user-project GPIO pads. It captures a flat vector of per-pad configuration words and shifts it out over a three-wire chain (serial_clock, serial_data, serial_load) to the per-pad control blocks. Those control blocks drive the padframe's mprj_io_* control inputs: mode, output enable, input disable, holdover, analog selects and drive mode. It sits between the housekeeping register file and the GPIO control chain, directly upstream of the padframe.

## Interface
- PADS, 38: number of user pads in the chain; matches `MPRJ_IO_PADS.
- CFG_BITS, 13: configuration bits per pad.
- CLK_DIV, 2: core-clock cycles per serial_clock half-period; legal range ≥1.
- clock  input  1  core clock; all state changes on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- xfer  input  1  start request; sampled only while idle.
- cfg_data  input  PADS*CFG_BITS  configuration image; pad p occupies bits [p*CFG_BITS +: CFG_BITS].
- busy  output  1  high while a transfer is in progress.
- done  output  1  one-cycle pulse when a transfer completes.
- serial_clock  output  1  chain shift clock; the chain captures on its rising edge.
- serial_data  output  1  chain data.
- serial_load  output  1  chain load strobe; control blocks latch their shift registers while it is high.

## Operation
- TOTAL = PADS*CFG_BITS.
- Bit counter width: clog2(TOTAL+1).
- Divider counter width: max(1, clog2(CLK_DIV)).
- States: IDLE, LOW, HIGH, LOAD.
- IDLE:
  - All outputs 0.
  - When xfer=1, copy cfg_data into an internal shift register, clear the bit counter and divider, and go to LOW.
- Shift order: pad PADS-1 is sent first, pad 0 last, each pad MSB first. After TOTAL shifts, pad 0's word sits in the control block nearest the loader.
- LOW:
  - serial_clock=0.
  - serial_data = current bit (shift register MSB).
  - Lasts CLK_DIV cycles, then go to HIGH.
- HIGH:
  - serial_clock=1.
  - serial_data held at the same value.
  - Lasts CLK_DIV cycles.
  - On exit, shift the register left by one and increment the bit counter.
  - If the counter has reached TOTAL, go to LOAD; otherwise go to LOW.
- LOAD:
  - serial_clock=0, serial_data=0, serial_load=1.
  - Lasts CLK_DIV cycles.
  - On exit, go to IDLE and pulse done for one cycle.
- busy=1 in LOW, HIGH and LOAD.
- xfer is ignored while busy, including on the done cycle; cfg_data changes during a transfer have no effect.
- xfer held high continuously starts a new transfer on the cycle after done.
- Reset asserted mid-transfer, asynchronously:
  - All outputs go to 0 and the state returns to IDLE.
  - serial_load is never asserted for a partial image.
  - The chain keeps partially shifted contents; the next complete transfer overwrites them.

## Timing
- Reset values: busy=0, done=0, serial_clock=0, serial_data=0, serial_load=0.
- When xfer=1 is sampled at edge N:
  - busy=1 from cycle N+1.
  - The first serial_data bit (cfg_data[TOTAL-1]) is valid from N+1.
- Rising edge k of serial_clock (k=1..TOTAL) occurs at cycle N+1+(2k-1)*CLK_DIV.
- serial_data is stable for CLK_DIV cycles before and CLK_DIV cycles after each serial_clock rising edge.
- serial_load is high for cycles N+1+2*TOTAL*CLK_DIV through N+(2*TOTAL+1)*CLK_DIV.
- busy is high for exactly (2*TOTAL+1)*CLK_DIV cycles.
- done=1 and busy=0 in cycle N+1+(2*TOTAL+1)*CLK_DIV.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset check: hold resetn=0, then release. Required: all outputs 0; with xfer=0 for 100 cycles, outputs stay 0.
- Bit order (PADS=2, CFG_BITS=13, CLK_DIV=2, cfg_data=26'h2AB_CDEF, xfer pulse):
  - Required: 26 serial_clock rising edges.
  - Bits sampled at the rising edges equal cfg_data[25] down to cfg_data[0].
  - serial_load is high for 2 cycles after the last edge.
  - done occurs 107 cycles after xfer is sampled.
- Defaults (PADS=38, CLK_DIV=2, cfg_data = alternating 13'h1803/13'h0403 per pad):
  - Required: 494 rising edges.
  - busy high for 1978 cycles.
  - A chain model of 38 control blocks latches each pad's word correctly.
- Busy masking (CLK_DIV=1): pulse xfer again at edge 10 and on the done cycle. Required: exactly one transfer; edge count = TOTAL.
- Back-to-back: hold xfer=1 continuously. Required: the second transfer's first LOW phase starts on the cycle immediately after done; serial_load is pulsed once per transfer.
- Reset mid-shift:
  - Assert resetn=0 at bit 100.
  - Required: outputs 0 asynchronously, with no serial_load pulse.
  - A following full transfer leaves the chain model holding the new image.
